// File: rtl/axis_byte_packer.sv
// Byte-to-word AXI-stream packer: MSB-first bytes assembled into one BYTES*8-bit word.
// Define PACKER_TIMEOUT_EN to enable the inter-byte timeout that discards stale partial words.
module axis_byte_packer #(
   parameter int BYTES          = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [BYTES*8-1:0]           m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [$clog2(BYTES+1)-1:0]   fill_count,
   output logic                         drop
);

   localparam int W  = BYTES * 8;
   localparam int CW = $clog2(BYTES + 1);

   typedef enum logic {ST_FILL, ST_HOLD} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    word_q, word_d;
   logic [CW-1:0]   fill_q, fill_d;
   logic            s_hs;
   logic            expire;

   assign s_hs = s_axis_tvalid && (state_q == ST_FILL);

`ifdef PACKER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic          drop_q;

   assign expire = (state_q == ST_FILL) && (fill_q != '0) &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      timer_d = timer_q + TW'(1);
      if (expire || s_hs || (state_q != ST_FILL) || (fill_q == '0))
         timer_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         drop_q  <= expire;
      end
   end

   assign drop = drop_q;
`else
   assign expire = 1'b0;
   assign drop   = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only; next-state values come from always_comb.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         word_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         fill_q  <= fill_d;
      end
   end

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      fill_d  = fill_q;
      unique case (state_q)
         ST_FILL: begin
            if (expire) begin
               // A byte landing on the expiry cycle starts the next word.
               word_d = s_hs ? {{(W-8){1'b0}}, s_axis_tdata} : '0;
               fill_d = s_hs ? CW'(1) : '0;
            end else if (s_hs) begin
               word_d = {word_q[W-9:0], s_axis_tdata};
               fill_d = fill_q + CW'(1);
               if (fill_q == CW'(BYTES - 1))
                  state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (m_axis_tready) begin
               state_d = ST_FILL;
               word_d  = '0;
               fill_d  = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_comb begin
      s_axis_tready = (state_q == ST_FILL);
      m_axis_tvalid = (state_q == ST_HOLD);
      m_axis_tdata  = word_q;
      fill_count    = fill_q;
   end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: table-driven words plus hand-written corner sequences.
module tb_axis_byte_packer;

   localparam int BYTES = 8;
   localparam int TO    = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [63:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic [3:0]  fill;
   logic        drop;

   axis_byte_packer #(.BYTES(BYTES), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .fill_count    (fill),
      .drop          (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [0:7][7:0] b;
      logic [63:0]     exp;
      int              delay;
   } vec_t;

   vec_t        vecs [4];
   logic [63:0] sb [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          valid_cycles = 0;
   int          drop_pulses = 0;
   int          words_seen = 0;
   int          words_pushed = 0;
   int          last_byte_cyc = 0;
   int          word_cyc = 0;
   int          prev_word_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every word handshake.
   always @(negedge clk) begin
      if (m_tvalid) valid_cycles++;
      if (drop) drop_pulses++;
      if (m_tvalid && m_tready) begin
         words_seen++;
         prev_word_cyc = word_cyc;
         word_cyc      = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", m_tdata);
         end else begin
            check("word", m_tdata, sb.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         s_tdata  = b;
         s_tvalid = 1'b1;
         ok = s_tready;
         if (ok) last_byte_cyc = cyc;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      if (!ok) fail_timeout("send_byte");
   endtask

   task automatic push_exp(input logic [63:0] w);
      sb.push_back(w);
      words_pushed++;
   endtask

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = m_tvalid;
      end
      if (!seen) fail_timeout("wait_valid");
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() != 0) fail_timeout("wait_drain");
   endtask

   initial begin
      vecs[0] = '{{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}, 64'h0123456789ABCDEF, 0};
      vecs[1] = '{{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h00, 8'hFF}, 64'hFF00FF00A55A00FF, 3};
      vecs[2] = '{{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 64'h8000000000000001, 0};
      vecs[3] = '{{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0}, 64'h123456789ABCDEF0, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_tready", 64'(s_tready), 64'd1);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_drop", 64'(drop), 64'd0);
      check("rst_tdata", m_tdata, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven words with optional downstream stall
      foreach (vecs[k]) begin
         int vc0;
         m_tready = (vecs[k].delay == 0);
         push_exp(vecs[k].exp);
         vc0 = valid_cycles;
         for (int j = 0; j < BYTES; j++) send_byte(vecs[k].b[j]);
         wait_valid();
         check("hold_fill", 64'(fill), 64'(BYTES));
         check("hold_tready", 64'(s_tready), 64'd0);
         if (vecs[k].delay > 0) begin
            repeat (vecs[k].delay) @(posedge clk);
            #1;
            m_tready = 1'b1;
         end
         wait_drain();
         check("latency", 64'(word_cyc), 64'(last_byte_cyc + 1 + vecs[k].delay));
         check("valid_len", 64'(valid_cycles - vc0), 64'(vecs[k].delay + 1));
         check("fill_after", 64'(fill), 64'd0);
      end

      // Backpressure: held word stable, extra bytes stall without loss
      begin
         int unstable = 0;
         int rdy_high = 0;
         logic [63:0] held;
         m_tready = 1'b0;
         push_exp(64'hDEADBEEFCAFEF00D);
         push_exp(64'h1122334455667788);
         send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
         send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
         fork
            begin
               send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
               send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
            end
            begin
               wait_valid();
               held = m_tdata;
               for (int i = 0; i < 20; i++) begin
                  @(negedge clk);
                  if (m_tdata !== held || !m_tvalid) unstable++;
                  if (s_tready) rdy_high++;
               end
               @(posedge clk);
               #1;
               m_tready = 1'b1;
            end
         join
         wait_drain();
         check("bp_stable", 64'(unstable), 64'd0);
         check("bp_tready_low", 64'(rdy_high), 64'd0);
      end

      // Back-to-back: 16 bytes streamed, one idle cycle between words
      push_exp(64'h0001020304050607);
      push_exp(64'h08090A0B0C0D0E0F);
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      wait_drain();
      check("b2b_gap", 64'(word_cyc - prev_word_cyc), 64'(BYTES + 1));

      // Reset mid-word discards partial bytes
      send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
      check("partial_fill", 64'(fill), 64'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_fill", 64'(fill), 64'd0);
      check("midrst_tdata", m_tdata, 64'd0);
      rst = 1'b0;
      push_exp(64'hAAAAAAAAAAAAAAAA);
      for (int i = 0; i < BYTES; i++) send_byte(8'hAA);
      wait_drain();

`ifdef PACKER_TIMEOUT_EN
      // Idle past the timeout: partial word dropped, next word packs cleanly
      begin
         int dp0 = drop_pulses;
         send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
         repeat (TO - 1) @(posedge clk);
         #1;
         check("to_no_early_drop", 64'(drop), 64'd0);
         check("to_fill_pre", 64'(fill), 64'd3);
         @(posedge clk);
         #1;
         check("to_drop", 64'(drop), 64'd1);
         check("to_fill", 64'(fill), 64'd0);
         @(posedge clk);
         #1;
         check("to_drop_len", 64'(drop_pulses - dp0), 64'd1);
         push_exp(64'h0102030405060708);
         for (int i = 1; i <= BYTES; i++) send_byte(8'(i));
         wait_drain();
      end
      // Byte on the expiry cycle becomes byte 1 of the new word
      send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
      repeat (TO - 1) @(posedge clk);
      send_byte(8'h5A);
      check("to_edge_drop", 64'(drop), 64'd1);
      check("to_edge_fill", 64'(fill), 64'd1);
      push_exp(64'h5A01020304050607);
      for (int i = 1; i < BYTES; i++) send_byte(8'(i));
      wait_drain();
`else
      // Without the timeout a partial word waits indefinitely
      begin
         int dp0 = drop_pulses;
         send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
         repeat (10000) @(posedge clk);
         #1;
         check("idle_drop", 64'(drop_pulses - dp0), 64'd0);
         check("idle_fill", 64'(fill), 64'd3);
         push_exp(64'hC0C1C2C3C4C5C6C7);
         for (int i = 3; i < BYTES; i++) send_byte(8'hC0 + 8'(i));
         wait_drain();
      end
`endif

      repeat (5) @(posedge clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("word_count", 64'(words_seen), 64'(words_pushed));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
